// File: rtl/regbank_arbiter.sv
// regbank_arbiter: two-port round-robin arbiter in front of a single-ported register bank.
// Latency: a req sampled in IDLE is acked two cycles later; one access every three cycles.
// Backpressure: requesters hold req until ack; a losing requester simply waits in IDLE.
// Option: define REGBANK_ARBITER_R0_ZERO_EN to make register 0 read as zero and drop its writes.
module regbank_arbiter #(
  parameter int addr_bits = 5,
  parameter int word_wide = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [addr_bits-1:0] a_addr,
  input  logic [word_wide-1:0] a_wdata,
  output logic [word_wide-1:0] a_rdata,
  output logic                 a_ack,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [addr_bits-1:0] b_addr,
  input  logic [word_wide-1:0] b_wdata,
  output logic [word_wide-1:0] b_rdata,
  output logic                 b_ack,
  output logic                 bank_read_enable,
  output logic                 bank_write_enable,
  output logic [addr_bits-1:0] bank_addr,
  inout  wire  [word_wide-1:0] bank_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t               state;
  state_t               state_nxt;
  // last_b doubles as the current grant: it is written at every grant, so
  // during ACCESS/RESP it names the side being served.
  logic                 last_b;
  logic                 we_q;
  logic                 pick_b;
  logic                 zero_hit;
  logic                 drive_bus;
  logic [word_wide-1:0] wdata_q;

  // Lone requester wins; on a tie the side not served last wins.
  assign pick_b = b_req & (~a_req | ~last_b);

`ifdef REGBANK_ARBITER_R0_ZERO_EN
  // Register 0 is hardwired: the bank is never touched for it.
  assign zero_hit = (bank_addr == '0);
`else
  assign zero_hit = 1'b0;
`endif

  assign bank_data = drive_bus ? wdata_q : {word_wide{1'bz}};

  // State register; reset drops straight to IDLE, aborting any access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus bank enables, bus drive and acks decoded from state.
  always_comb begin
    state_nxt         = state;
    bank_read_enable  = 1'b0;
    bank_write_enable = 1'b0;
    drive_bus         = 1'b0;
    a_ack             = 1'b0;
    b_ack             = 1'b0;
    case (state)
      IDLE: begin
        if (a_req || b_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt = RESP;
        if (!zero_hit) begin
          bank_write_enable = we_q;
          bank_read_enable  = ~we_q;
          drive_bus         = we_q;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        a_ack     = ~last_b;
        b_ack     = last_b;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and request latch; bank_addr holds between accesses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_b    <= 1'b1;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      bank_addr <= '0;
    end else if (state == IDLE && (a_req || b_req)) begin
      last_b    <= pick_b;
      we_q      <= pick_b ? b_we    : a_we;
      bank_addr <= pick_b ? b_addr  : a_addr;
      wdata_q   <= pick_b ? b_wdata : a_wdata;
    end
  end

  // Read data capture at the end of a read ACCESS into the granted side only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (state == ACCESS && !we_q) begin
      if (last_b) begin
        b_rdata <= zero_hit ? '0 : bank_data;
      end else begin
        a_rdata <= zero_hit ? '0 : bank_data;
      end
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// tb_regbank_arbiter: directed plus random traffic against a transaction-level model.
// Latency: model expects ack two cycles after grant, three-cycle access spacing.
// Backpressure: bench requesters hold req until ack, then drop for one IDLE cycle.
module tb_regbank_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REGBANK_ARBITER_R0_ZERO_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  logic          clock   = 1'b0;
  logic          reset_n = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          a_ack, b_ack, bank_read_enable, bank_write_enable;
  logic [AW-1:0] bank_addr;
  wire  [DW-1:0] bank_data;

  int n_chk  = 0;
  int n_fail = 0;
  int a_cnt  = 0;
  int b_cnt  = 0;

  regbank_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
    .bank_read_enable(bank_read_enable), .bank_write_enable(bank_write_enable),
    .bank_addr(bank_addr), .bank_data(bank_data)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h111;
  endfunction

  // Register bank: drives on read enable, commits on write enable at the clock edge.
  logic [DW-1:0] bank_mem [32];
  assign bank_data = bank_read_enable ? bank_mem[bank_addr] : {DW{1'bz}};
  always @(posedge clock) if (bank_write_enable) bank_mem[bank_addr] <= bank_data;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access, started at cycle t0.
  logic [DW-1:0] shadow [32];
  int            mc = 0;
  int            t0 = 0;
  bit            t_vld = 1'b0, t_b = 1'b0, t_we = 1'b0, last_b = 1'b1;
  logic [AW-1:0] t_addr = '0, m_addr = '0;
  logic [DW-1:0] t_wd = '0, m_ra = '0, m_rb = '0;

  always @(posedge clock or negedge reset_n) begin : model
    bit idle_now, who, zh;
    if (!reset_n) begin
      t_vld = 1'b0; last_b = 1'b1; m_ra = '0; m_rb = '0; m_addr = '0;
    end else begin
      idle_now = !t_vld;
      zh = R0 && (t_addr == 0);
      if (t_vld && mc == t0 + 1) begin
        if (t_we) begin
          if (!zh) shadow[t_addr] = t_wd;
        end else if (t_b) begin
          m_rb = zh ? '0 : shadow[t_addr];
        end else begin
          m_ra = zh ? '0 : shadow[t_addr];
        end
      end
      if (t_vld && mc == t0 + 2) t_vld = 1'b0;
      if (idle_now && (a_req || b_req)) begin
        if (a_req && b_req) who = !last_b;
        else                who = b_req;
        t_vld = 1'b1; t0 = mc; t_b = who; last_b = who;
        t_we   = who ? b_we    : a_we;
        t_addr = who ? b_addr  : a_addr;
        t_wd   = who ? b_wdata : a_wdata;
        m_addr = t_addr;
      end
      mc++;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin : compare
    bit acc, rsp, zh;
    acc = t_vld && (mc == t0 + 1);
    rsp = t_vld && (mc == t0 + 2);
    zh  = R0 && (t_addr == 0);
    if (a_ack) a_cnt++;
    if (b_ack) b_cnt++;
    chk("a_ack", a_ack, rsp && !t_b);
    chk("b_ack", b_ack, rsp && t_b);
    chk("bank_write_enable", bank_write_enable, acc && t_we && !zh);
    chk("bank_read_enable", bank_read_enable, acc && !t_we && !zh);
    chk("bank_addr", bank_addr, m_addr);
    chk("a_rdata", a_rdata, m_ra);
    chk("b_rdata", b_rdata, m_rb);
    if (acc && t_we && !zh)       chk("bank_data_wr", bank_data, t_wd);
    else if (acc && !t_we && !zh) chk("bank_data_rd", bank_data, shadow[t_addr]);
    else chk("bank_data_idle", (bank_data === {DW{1'bz}}) || (bank_data === '0), 1'b1);
  end

  // One request from one side; returns ack latency and whether any bank enable was seen.
  task automatic xact(input bit b, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                      output int lat, output bit saw_en);
    lat = -1; saw_en = 1'b0;
    if (b) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
    else   begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (bank_write_enable || bank_read_enable) saw_en = 1'b1;
      if (b ? b_ack : a_ack) begin lat = k; break; end
    end
    @(posedge clock); #1;
    a_req = 0; b_req = 0;
  endtask

  initial begin
    int lat, b0, nack;
    bit saw, a_seen, b_seen;
    int ack_k [4];
    bit ack_w [4];
    for (int i = 0; i < 32; i++) begin
      bank_mem[i] <= init_val(i);
      shadow[i] = init_val(i);
    end

    // Reset values.
    #1 reset_n = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_we", bank_write_enable, 0);
    chk("rst_re", bank_read_enable, 0);
    chk("rst_addr", bank_addr, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    @(posedge clock); #1 reset_n = 1;

    // Single write then read from A.
    b0 = b_cnt;
    xact(0, 1, 5'd5, 32'hDEADBEEF, lat, saw);
    chk("wr5_latency", 32'(lat), 2);
    xact(0, 0, 5'd5, '0, lat, saw);
    chk("rd5_latency", 32'(lat), 2);
    chk("rd5_a_rdata", a_rdata, 32'hDEADBEEF);
    chk("rd5_no_b_ack", 32'(b_cnt - b0), 0);

    // Register 0 write/read.
    xact(0, 1, 5'd0, 32'hFFFFFFFF, lat, saw);
    chk("r0_wr_latency", 32'(lat), 2);
    chk("r0_wr_enable_seen", saw, R0 ? 1'b0 : 1'b1);
    xact(0, 0, 5'd0, '0, lat, saw);
    chk("r0_rd_latency", 32'(lat), 2);
    chk("r0_rd_enable_seen", saw, R0 ? 1'b0 : 1'b1);
    chk("r0_rd_a_rdata", a_rdata, R0 ? 32'h0 : 32'hFFFFFFFF);

    // Tie straight after reset: A, B, A, B at acks 2, 5, 8, 11.
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;
    a_req = 1; a_we = 0; a_addr = 5'd1;
    b_req = 1; b_we = 0; b_addr = 5'd2;
    nack = 0;
    for (int k = 0; k < 20 && nack < 4; k++) begin
      @(negedge clock);
      if (a_ack) begin ack_k[nack] = k; ack_w[nack] = 0; nack++; end
      else if (b_ack) begin ack_k[nack] = k; ack_w[nack] = 1; nack++; end
    end
    @(posedge clock); #1;
    a_req = 0; b_req = 0;
    chk("tie_ack_count", 32'(nack), 4);
    for (int i = 0; i < 4; i++) begin
      chk("tie_order", (i < nack) ? ack_w[i] : 1'bx, (i % 2 == 1) ? 1'b1 : 1'b0);
      chk("tie_cycle", (i < nack) ? 32'(ack_k[i]) : 32'hFFFFFFFF, 32'(2 + 3 * i));
    end
    chk("tie_a_rdata", a_rdata, init_val(1));
    chk("tie_b_rdata", b_rdata, init_val(2));

    // Reset in the middle of a B write to register 9.
    b0 = b_cnt;
    b_req = 1; b_we = 1; b_addr = 5'd9; b_wdata = 32'h12345678;
    @(negedge clock);
    @(negedge clock);
    chk("mid_we_before", bank_write_enable, 1);
    chk("mid_addr_before", bank_addr, 5'd9);
    chk("mid_data_before", bank_data, 32'h12345678);
    #2 reset_n = 0; b_req = 0;
    #1;
    chk("mid_we_rst", bank_write_enable, 0);
    chk("mid_re_rst", bank_read_enable, 0);
    chk("mid_b_ack_rst", b_ack, 0);
    chk("mid_addr_rst", bank_addr, 0);
    chk("mid_a_rdata_rst", a_rdata, 0);
    chk("mid_b_rdata_rst", b_rdata, 0);
    @(posedge clock);
    @(posedge clock); #1 reset_n = 1;
    repeat (3) @(posedge clock); #1;
    chk("mid_no_b_ack", 32'(b_cnt - b0), 0);
    chk("mid_bank9", bank_mem[9], 32'hC0DE0999);
    xact(0, 0, 5'd9, '0, lat, saw);
    chk("mid_rd9", a_rdata, 32'hC0DE0999);

    // Random traffic; requesters also scramble fields while waiting.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      a_seen = a_ack; b_seen = b_ack;
      @(posedge clock); #1;
      if (a_req && a_seen) a_req = 0;
      else if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req = 1; a_we = 1'($urandom_range(0, 1)); a_addr = 5'($urandom_range(0, 7)); a_wdata = $urandom;
      end else if (a_req && $urandom_range(0, 3) == 0) begin
        a_we = 1'($urandom_range(0, 1)); a_addr = 5'($urandom_range(0, 7)); a_wdata = $urandom;
      end
      if (b_req && b_seen) b_req = 0;
      else if (!b_req && $urandom_range(0, 2) == 0) begin
        b_req = 1; b_we = 1'($urandom_range(0, 1)); b_addr = 5'($urandom_range(0, 7)); b_wdata = $urandom;
      end else if (b_req && $urandom_range(0, 3) == 0) begin
        b_we = 1'($urandom_range(0, 1)); b_addr = 5'($urandom_range(0, 7)); b_wdata = $urandom;
      end
    end
    a_req = 0; b_req = 0;
    repeat (6) @(posedge clock);
    #1;
    for (int i = 0; i < 32; i++) chk("final_bank_contents", bank_mem[i], shadow[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_arbiter.md
REGBANK_ARBITER -- requirements
Module: regbank_arbiter

Interface
REQ-001 The block SHALL have parameter addr_bits, default 5, bank address width.
REQ-002 The block SHALL have parameter word_wide, default 32, data word width.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports a_req / b_req, input, 1, access request, held high until the matching ack.
REQ-006 The block SHALL have ports a_we / b_we, input, 1, 1 = write and 0 = read, qualified by req.
REQ-007 The block SHALL have ports a_addr / b_addr, input, addr_bits, target register.
REQ-008 The block SHALL have ports a_wdata / b_wdata, input, word_wide, write data.
REQ-009 The block SHALL have ports a_rdata / b_rdata, output, word_wide, registered read data.
REQ-010 The block SHALL have ports a_ack / b_ack, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port bank_read_enable, output, 1, drives the bank read_enable.
REQ-012 The block SHALL have port bank_write_enable, output, 1, drives the bank write_enable.
REQ-013 The block SHALL have port bank_addr, output, addr_bits, drives the bank addr_bus.
REQ-014 The block SHALL have port bank_data, inout, word_wide, shared with the bank data_bus.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
- IDLE -> ACCESS when any req is high.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-016 In IDLE with exactly one req high, that requester SHALL be granted; with both high, the requester not granted last SHALL be granted (round-robin).
REQ-017 The granted requester's we, addr and wdata SHALL be latched at the IDLE->ACCESS edge; later changes are ignored until its ack.
REQ-018 During ACCESS, bank_addr SHALL equal the latched address.
- Write: bank_write_enable = 1, bank_read_enable = 0, bank_data driven with the latched wdata.
- Read: bank_read_enable = 1, bank_write_enable = 0, bank_data = Z.
REQ-019 On the ACCESS->RESP edge of a read, bank_data SHALL be captured into the granted requester's rdata; the other rdata SHALL hold its value.
REQ-020 In RESP, the granted requester's ack SHALL be 1 for exactly one cycle, and both bank enables SHALL be 0.
REQ-021 Latency from a req sampled in IDLE to its ack SHALL be 2 cycles, and throughput SHALL be one access per 3 cycles.
REQ-022 A req still high in the IDLE cycle after its ack SHALL be treated as a new transaction.
REQ-023 bank_data SHALL be Z in every state except ACCESS-write, and both enables SHALL never be high together.
REQ-024 a_ack and b_ack SHALL never be high together.
REQ-025 Outside ACCESS, bank_addr SHALL hold its last value.

Reset
REQ-026 reset_n low SHALL immediately force:
- state IDLE;
- both enables 0;
- bank_data Z;
- a_ack and b_ack 0;
- a_rdata, b_rdata and bank_addr 0;
- last-grant pointer to B, so A wins the first tie.
REQ-027 Reset asserted during ACCESS SHALL abort the access with no ack; a write whose enable is removed before the clock edge SHALL not commit.
REQ-028 After reset_n rises, the first arbitration SHALL occur on the next rising edge.

Configuration
REQ-029 Macro REGBANK_ARBITER_R0_ZERO_EN SHALL control the register-0 behaviour.
- Defined: a write to address 0 SHALL keep bank_write_enable 0 in ACCESS and still ack.
- Defined: a read from address 0 SHALL keep bank_read_enable 0, bank_data Z, and capture all-zero rdata.
- Defined: timing SHALL be unchanged.
- Undefined: address 0 SHALL behave as any other address.

Verification
REQ-030 Single write/read: A writes 0xDEADBEEF to address 5, then A reads address 5 -> a_ack 2 cycles after each req, a_rdata = 0xDEADBEEF, b_ack never high.
REQ-031 Tie after reset: a_req and b_req rise together, both held high -> grant order A, B, A, B, with acks 3 cycles apart.
REQ-032 Bus safety: random A/B traffic for 10000 cycles -> enables never both 1, bank_data driven only in write ACCESS, acks mutually exclusive.
REQ-033 Mid-access reset: reset_n pulsed low during a B write of 0x12345678 to address 9 -> no b_ack, register 9 retains its old value, outputs at reset values.
REQ-034 Register 0, macro defined: write 0xFFFFFFFF to address 0, then read it -> bank_write_enable stays 0, rdata = 0, ack timing unchanged.
REQ-035 Register 0, macro undefined: same stimulus as REQ-034 -> rdata = 0xFFFFFFFF.
